regfile_wb_sched: RTL and testbench
===================================

// Module: regfile_wb_sched
// PURPOSE
//   Write-back scheduler and scoreboard for the single-write-port register file.
//   Shares the one RF write port between the execute unit (EXU) and the load/store unit (LSU) using round-robin arbitration.
//   Tracks pending destination registers so that decode can stall on RAW/WAW hazards.
//   Sits between decode/EXU/LSU and the RF write port; the RF read ports are not touched.
// PARAMETERS
//   ADDR_WIDTH  5   RF index width; 2**ADDR_WIDTH architectural registers, x0 hard-wired zero
//   DATA_WIDTH  32  RF data width
// PORTS
//   clk          in   1    single clock, all state updates on posedge
//   rst_n        in   1    reset: synchronous, active-low
//   issue_valid  in   1    decode issues an instruction that writes issue_rd
//   issue_rd     in   AW   destination of the issued instruction
//   issue_ready  out  1    high when issue_rd is not pending (or is x0)
//   rs1, rs2     in   AW   source indices queried by decode
//   hazard       out  1    comb: rs1 or rs2 is pending and nonzero
//   exu_valid    in   1    EXU write-back request
//   exu_rd       in   AW   EXU destination
//   exu_wdata    in   DW   EXU result
//   exu_ready    out  1    EXU request granted this cycle
//   lsu_valid    in   1    LSU write-back request
//   lsu_rd       in   AW   LSU destination
//   lsu_wdata    in   DW   LSU result
//   lsu_ready    out  1    LSU request granted this cycle
//   rf_wen       out  1    registered RF write enable
//   rf_waddr     out  AW   registered RF write address
//   rf_wdata     out  DW   registered RF write data
//   wb_err       out  1    sticky: a write-back targeted a non-pending, nonzero rd
// BEHAVIOUR
//   Reset (rst_n=0 at posedge): pending=0, rr_ptr=EXU, rf_wen=0, rf_waddr=0, rf_wdata=0, wb_err=0.
//   Reset mid-operation drops all in-flight grants and pending bits; no RF write is issued that cycle.
//   Handshakes:
//     - An issue transfers when issue_valid && issue_ready.
//     - A write-back transfers when x_valid && x_ready.
//     - Requesters hold rd/wdata stable until ready.
//   Arbitration:
//     - Grants at most one source per cycle; *_ready are combinational from the valids and rr_ptr.
//     - Only one requester valid -> it is granted.
//     - Both valid -> the source named by rr_ptr is granted; rr_ptr then flips to the other source.
//     - rr_ptr changes only on a two-way contention grant.
//   Write port:
//     - Latency 1: a grant at cycle N gives rf_wen=1 with that rd/wdata in cycle N+1.
//     - rf_wen=0 in any cycle after a cycle with no grant.
//     - Grant with rd==0: handshake completes, rf_wen stays 0, wb_err is unaffected.
//   Scoreboard (pending[2**AW-1:1]; pending[0] is constant 0):
//     - Set pending[issue_rd] on issue transfer when issue_rd!=0.
//     - Clear pending[rf_waddr] on the edge that ends a cycle with rf_wen=1 (i.e. when the RF actually writes).
//     - A set and a clear of different indices in the same cycle both take effect.
//     - A same-index set and clear cannot coexist, because issue_ready=0 while the index is pending.
//     - hazard is driven from the pending vector only; it stays high through the rf_wen cycle.
//     - So a consumer issues the cycle after the write (no RF bypass).
//   wb_err: set on a grant whose rd!=0 and pending[rd]==0; cleared only by reset.
// STRUCTURE
//   Shared package regfile_pkg:
//     - AW/DW defaults
//     - typedef src_e {SRC_EXU, SRC_LSU} for rr_ptr
//     - typedef wb_req_t {rd, wdata}
//   Sub-module rr_arb2: 2-way round-robin arbiter (req[1:0], grant[1:0], ptr state) used for the grant logic.
//   Scoreboard, output register and error flag are inline.
// TESTING
//   1. Reset with exu_valid=lsu_valid=1 held -> rf_wen=0, pending=0, wb_err=0 at cycle 1; first grant goes to EXU.
//   2. Issue rd=5, then EXU writes rd=5 data 0xDEADBEEF:
//      - hazard(rs1=5)=1 until and including the rf_wen cycle
//      - rf_waddr=5, rf_wdata=0xDEADBEEF one cycle after the grant
//      - hazard=0 on the next cycle
//   3. Both sources valid for 4 cycles (EXU rd=1..., LSU rd=2...) -> grants alternate EXU,LSU,EXU,LSU; rf_wen is high in 4 consecutive cycles.
//   4. Issue rd=7 while rd=7 is pending -> issue_ready=0 until the cycle after rf_wen with rf_waddr=7; rd=0 issue is always ready.
//   5. LSU writes rd=0 data 0x1234 -> lsu_ready=1, rf_wen stays 0, wb_err=0; EXU writes non-pending rd=9 -> wb_err=1 and stays 1.
//   6. Issue rd=3 and a write-back to pending rd=4 in the same cycle, then assert rst_n=0 -> both bits clear and rf_wen=0 after reset.

Source files
------------

// File: rtl/regfile_pkg.sv
// Shared types for the register-file write-back scheduler: source encoding and write-back request.
package regfile_pkg;

  localparam int AW = 5;
  localparam int DW = 32;

  typedef enum logic {
    SRC_EXU = 1'b0,
    SRC_LSU = 1'b1
  } src_e;

  typedef struct packed {
    logic [AW-1:0] rd;
    logic [DW-1:0] wdata;
  } wb_req_t;

endpackage

// File: rtl/regfile_wb_sched_if.sv
// Decode/EXU/LSU-facing bus of the write-back scheduler, plus the RF write port it drives.
interface regfile_wb_sched_if #(
  parameter int ADDR_WIDTH = regfile_pkg::AW,
  parameter int DATA_WIDTH = regfile_pkg::DW
);

  logic                  issue_valid;
  logic [ADDR_WIDTH-1:0] issue_rd;
  logic                  issue_ready;
  logic [ADDR_WIDTH-1:0] rs1;
  logic [ADDR_WIDTH-1:0] rs2;
  logic                  hazard;
  logic                  exu_valid;
  logic [ADDR_WIDTH-1:0] exu_rd;
  logic [DATA_WIDTH-1:0] exu_wdata;
  logic                  exu_ready;
  logic                  lsu_valid;
  logic [ADDR_WIDTH-1:0] lsu_rd;
  logic [DATA_WIDTH-1:0] lsu_wdata;
  logic                  lsu_ready;
  logic                  rf_wen;
  logic [ADDR_WIDTH-1:0] rf_waddr;
  logic [DATA_WIDTH-1:0] rf_wdata;
  logic                  wb_err;

  modport master (
    output issue_valid, issue_rd, rs1, rs2,
    output exu_valid, exu_rd, exu_wdata,
    output lsu_valid, lsu_rd, lsu_wdata,
    input  issue_ready, hazard, exu_ready, lsu_ready,
    input  rf_wen, rf_waddr, rf_wdata, wb_err
  );

  modport slave (
    input  issue_valid, issue_rd, rs1, rs2,
    input  exu_valid, exu_rd, exu_wdata,
    input  lsu_valid, lsu_rd, lsu_wdata,
    output issue_ready, hazard, exu_ready, lsu_ready,
    output rf_wen, rf_waddr, rf_wdata, wb_err
  );

endinterface

// File: rtl/regfile_wb_sched_rr_arb2.sv
// Two-way round-robin arbiter: bit 0 is EXU, bit 1 is LSU; the pointer moves only on contention.
module rr_arb2
  import regfile_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] req,
  output logic [1:0] grant
);

  src_e ptr;

  always_comb begin
    grant = req;
    if (req == 2'b11) begin
      grant = (ptr == SRC_EXU) ? 2'b01 : 2'b10;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ptr <= SRC_EXU;
    end else if (req == 2'b11) begin
      ptr <= (ptr == SRC_EXU) ? SRC_LSU : SRC_EXU;
    end
  end

endmodule

// File: rtl/regfile_wb_sched.sv
// Write-back scheduler: shares the single RF write port between EXU and LSU and keeps
// a pending-destination scoreboard so decode can stall on RAW/WAW hazards.
module regfile_wb_sched
  import regfile_pkg::*;
#(
  parameter int ADDR_WIDTH = AW,
  parameter int DATA_WIDTH = DW
) (
  input logic               clk,
  input logic               rst_n,
  regfile_wb_sched_if.slave bus
);

  localparam int NREG = 2 ** ADDR_WIDTH;

  logic [NREG-1:0]       pending;
  logic [NREG-1:0]       pending_nxt;
  logic [1:0]            req;
  logic [1:0]            grant;
  logic                  win_valid;
  logic [ADDR_WIDTH-1:0] win_rd;
  logic [DATA_WIDTH-1:0] win_wdata;
  logic                  issue_fire;

  // Requests are masked during reset so no handshake completes while state is being cleared.
  assign req = rst_n ? {bus.lsu_valid, bus.exu_valid} : 2'b00;

  rr_arb2 u_arb (
    .clk   (clk),
    .rst_n (rst_n),
    .req   (req),
    .grant (grant)
  );

  assign bus.exu_ready = grant[0];
  assign bus.lsu_ready = grant[1];

  always_comb begin
    win_valid = |grant;
    win_rd    = grant[1] ? bus.lsu_rd    : bus.exu_rd;
    win_wdata = grant[1] ? bus.lsu_wdata : bus.exu_wdata;
  end

  assign bus.issue_ready = (bus.issue_rd == '0) || !pending[bus.issue_rd];
  assign issue_fire      = bus.issue_valid && bus.issue_ready;
  // pending[0] is held at zero, so x0 sources never report a hazard.
  assign bus.hazard      = pending[bus.rs1] || pending[bus.rs2];

  always_comb begin
    pending_nxt = pending;
    if (bus.rf_wen) begin
      pending_nxt[bus.rf_waddr] = 1'b0;
    end
    if (issue_fire && (bus.issue_rd != '0)) begin
      pending_nxt[bus.issue_rd] = 1'b1;
    end
    pending_nxt[0] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pending      <= '0;
      bus.rf_wen   <= 1'b0;
      bus.rf_waddr <= '0;
      bus.rf_wdata <= '0;
      bus.wb_err   <= 1'b0;
    end else begin
      pending    <= pending_nxt;
      bus.rf_wen <= win_valid && (win_rd != '0);
      if (win_valid) begin
        bus.rf_waddr <= win_rd;
        bus.rf_wdata <= win_wdata;
      end
      // Writing back a register nobody is waiting for means a lost or duplicated write-back.
      if (win_valid && (win_rd != '0) && !pending[win_rd]) begin
        bus.wb_err <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_regfile_wb_sched.sv
// Directed bench for regfile_wb_sched: expected RF writes go into a queue that a negedge monitor drains.
module tb_regfile_wb_sched;
  import regfile_pkg::*;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  regfile_wb_sched_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

  regfile_wb_sched #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int      vectors = 0;
  int      miscompares = 0;
  wb_req_t exp_q[$];
  wb_req_t mon_e;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    vectors++;
    if (act !== req) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at t=%0t", name, act, req, $time);
    end
  endtask

  task automatic nxt();
    @(posedge clk);
    #1;
  endtask

  task automatic neg();
    @(negedge clk);
  endtask

  task automatic push(input logic [AW-1:0] rd, input logic [DW-1:0] data);
    wb_req_t e;
    e.rd    = rd;
    e.wdata = data;
    exp_q.push_back(e);
  endtask

  always @(negedge clk) begin
    if (bus.rf_wen === 1'b1) begin
      if (exp_q.size() == 0) begin
        vectors++;
        miscompares++;
        $display("FAIL unexpected_rf_write: got addr 0x%0h data 0x%0h, expected no write at t=%0t",
                 bus.rf_waddr, bus.rf_wdata, $time);
      end else begin
        mon_e = exp_q.pop_front();
        check("rf_waddr", 32'(bus.rf_waddr), 32'(mon_e.rd));
        check("rf_wdata", bus.rf_wdata, mon_e.wdata);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst_n           = 1'b0;
    bus.issue_valid = 1'b0;
    bus.issue_rd    = '0;
    bus.rs1         = 5'd5;
    bus.rs2         = '0;
    bus.exu_valid   = 1'b1;
    bus.exu_rd      = '0;
    bus.exu_wdata   = 32'h11;
    bus.lsu_valid   = 1'b1;
    bus.lsu_rd      = '0;
    bus.lsu_wdata   = 32'h22;

    // 1: reset with both write-back sources requesting
    nxt();
    neg();
    check("rst_rf_wen", 32'(bus.rf_wen), 0);
    check("rst_rf_waddr", 32'(bus.rf_waddr), 0);
    check("rst_rf_wdata", bus.rf_wdata, 0);
    check("rst_wb_err", 32'(bus.wb_err), 0);
    check("rst_hazard", 32'(bus.hazard), 0);
    nxt();
    rst_n = 1'b1;
    neg();
    check("first_grant_exu", 32'(bus.exu_ready), 1);
    check("first_grant_not_lsu", 32'(bus.lsu_ready), 0);
    nxt();
    bus.exu_valid = 1'b0;
    bus.lsu_valid = 1'b0;
    neg();
    check("rd0_grant_no_wen", 32'(bus.rf_wen), 0);

    // 2: issue rd=5, EXU writes it back
    nxt();
    bus.issue_valid = 1'b1;
    bus.issue_rd    = 5'd5;
    neg();
    check("issue5_ready", 32'(bus.issue_ready), 1);
    check("hazard5_before", 32'(bus.hazard), 0);
    nxt();
    bus.issue_valid = 1'b0;
    neg();
    check("hazard5_pending", 32'(bus.hazard), 1);
    nxt();
    bus.exu_valid = 1'b1;
    bus.exu_rd    = 5'd5;
    bus.exu_wdata = 32'hDEADBEEF;
    push(5'd5, 32'hDEADBEEF);
    neg();
    check("exu5_ready", 32'(bus.exu_ready), 1);
    check("hazard5_grant", 32'(bus.hazard), 1);
    nxt();
    bus.exu_valid = 1'b0;
    neg();
    check("wen5", 32'(bus.rf_wen), 1);
    check("hazard5_wen_cycle", 32'(bus.hazard), 1);
    nxt();
    neg();
    check("hazard5_cleared", 32'(bus.hazard), 0);
    check("wen_after5", 32'(bus.rf_wen), 0);

    // 3: contention alternates EXU/LSU starting from a fresh pointer
    nxt();
    rst_n = 1'b0;
    neg();
    nxt();
    rst_n = 1'b1;
    for (int i = 1; i <= 5; i++) begin
      bus.issue_valid = 1'b1;
      bus.issue_rd    = 5'(i);
      neg();
      check("issue_seq_ready", 32'(bus.issue_ready), 1);
      nxt();
    end
    bus.issue_valid = 1'b0;
    bus.exu_valid = 1'b1; bus.exu_rd = 5'd1; bus.exu_wdata = 32'hA1;
    bus.lsu_valid = 1'b1; bus.lsu_rd = 5'd2; bus.lsu_wdata = 32'hB2;
    push(5'd1, 32'hA1);
    neg();
    check("rr0_exu", 32'(bus.exu_ready), 1);
    check("rr0_lsu", 32'(bus.lsu_ready), 0);
    nxt();
    bus.exu_rd = 5'd3; bus.exu_wdata = 32'hA3;
    push(5'd2, 32'hB2);
    neg();
    check("rr1_lsu", 32'(bus.lsu_ready), 1);
    check("rr1_exu", 32'(bus.exu_ready), 0);
    check("rr1_wen", 32'(bus.rf_wen), 1);
    nxt();
    bus.lsu_rd = 5'd4; bus.lsu_wdata = 32'hB4;
    push(5'd3, 32'hA3);
    neg();
    check("rr2_exu", 32'(bus.exu_ready), 1);
    check("rr2_wen", 32'(bus.rf_wen), 1);
    nxt();
    bus.exu_rd = 5'd5; bus.exu_wdata = 32'hA5;
    push(5'd4, 32'hB4);
    neg();
    check("rr3_lsu", 32'(bus.lsu_ready), 1);
    check("rr3_wen", 32'(bus.rf_wen), 1);
    nxt();
    bus.lsu_valid = 1'b0;
    push(5'd5, 32'hA5);
    neg();
    check("rr4_exu_alone", 32'(bus.exu_ready), 1);
    check("rr4_wen", 32'(bus.rf_wen), 1);
    nxt();
    bus.exu_valid = 1'b0;
    neg();
    check("rr5_wen", 32'(bus.rf_wen), 1);
    nxt();
    bus.rs1 = 5'd1;
    bus.rs2 = 5'd5;
    neg();
    check("rr_idle_wen", 32'(bus.rf_wen), 0);
    check("rr_all_cleared", 32'(bus.hazard), 0);

    // 4: WAW stall on rd=7; x0 issue never stalls
    nxt();
    bus.issue_rd = '0;
    neg();
    check("issue_x0_ready", 32'(bus.issue_ready), 1);
    nxt();
    bus.issue_valid = 1'b1;
    bus.issue_rd    = 5'd7;
    neg();
    check("issue7_first", 32'(bus.issue_ready), 1);
    nxt();
    bus.exu_valid = 1'b1; bus.exu_rd = 5'd7; bus.exu_wdata = 32'h77;
    push(5'd7, 32'h77);
    neg();
    check("issue7_stall", 32'(bus.issue_ready), 0);
    check("exu7_ready", 32'(bus.exu_ready), 1);
    nxt();
    bus.exu_valid = 1'b0;
    neg();
    check("issue7_stall_wen", 32'(bus.issue_ready), 0);
    nxt();
    neg();
    check("issue7_released", 32'(bus.issue_ready), 1);
    nxt();
    bus.issue_valid = 1'b0;
    bus.exu_valid = 1'b1; bus.exu_rd = 5'd7; bus.exu_wdata = 32'h78;
    push(5'd7, 32'h78);
    neg();
    check("exu7b_ready", 32'(bus.exu_ready), 1);
    nxt();
    bus.exu_valid = 1'b0;
    neg();
    nxt();

    // 5: x0 write-back is swallowed; non-pending write-back raises sticky error
    bus.lsu_valid = 1'b1; bus.lsu_rd = '0; bus.lsu_wdata = 32'h1234;
    neg();
    check("lsu_x0_ready", 32'(bus.lsu_ready), 1);
    nxt();
    bus.lsu_valid = 1'b0;
    neg();
    check("lsu_x0_no_wen", 32'(bus.rf_wen), 0);
    check("lsu_x0_no_err", 32'(bus.wb_err), 0);
    nxt();
    bus.exu_valid = 1'b1; bus.exu_rd = 5'd9; bus.exu_wdata = 32'h99;
    push(5'd9, 32'h99);
    neg();
    check("err_before", 32'(bus.wb_err), 0);
    nxt();
    bus.exu_valid = 1'b0;
    neg();
    check("err_set", 32'(bus.wb_err), 1);
    nxt();
    nxt();
    neg();
    check("err_sticky", 32'(bus.wb_err), 1);

    // 6: reset right after an issue and a write-back in the same cycle
    nxt();
    bus.issue_valid = 1'b1;
    bus.issue_rd    = 5'd4;
    neg();
    nxt();
    bus.issue_rd  = 5'd3;
    bus.exu_valid = 1'b1; bus.exu_rd = 5'd4; bus.exu_wdata = 32'h44;
    push(5'd4, 32'h44);
    neg();
    check("same_cycle_issue_ready", 32'(bus.issue_ready), 1);
    check("same_cycle_exu_ready", 32'(bus.exu_ready), 1);
    nxt();
    bus.issue_valid = 1'b0;
    bus.exu_valid   = 1'b0;
    bus.rs1 = 5'd3;
    bus.rs2 = 5'd4;
    rst_n = 1'b0;
    neg();
    check("pre_rst_hazard", 32'(bus.hazard), 1);
    nxt();
    rst_n = 1'b1;
    neg();
    check("post_rst_wen", 32'(bus.rf_wen), 0);
    check("post_rst_hazard", 32'(bus.hazard), 0);
    check("post_rst_issue3_ready", 32'(bus.issue_ready), 1);
    check("post_rst_err", 32'(bus.wb_err), 0);

    // a request presented during reset must not turn into a write
    nxt();
    rst_n = 1'b0;
    bus.exu_valid = 1'b1; bus.exu_rd = 5'd6; bus.exu_wdata = 32'h66;
    neg();
    nxt();
    bus.exu_valid = 1'b0;
    rst_n = 1'b1;
    neg();
    check("rst_drops_grant", 32'(bus.rf_wen), 0);

    nxt();
    neg();
    check("queue_drained", exp_q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
